clock_time_core: RTL and testbench

//  Digital-clock time base and time-setting controller, directly downstream of
//  the key debouncer. Consumes its debounced toggle-level key outputs (each

---
 rtl/clock_time_core.sv | 84 ++++++++
 tb/tb_clock_time_core.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/clock_time_core.sv
// clock_time_core: BCD HH:MM:SS time base with RUN / SET_HOUR / SET_MIN mode machine
//   clk       in   system clock
//   rst_n     in   asynchronous active-low reset
//   key_tgl   in   [3] debounced toggle levels, [0]=mode [1]=inc [2]=dec
//   hour_bcd  out  [8] hours 00..23, BCD
//   min_bcd   out  [8] minutes 00..59, BCD
//   sec_bcd   out  [8] seconds 00..59, BCD
//   mode      out  [2] 00=RUN 01=SET_HOUR 10=SET_MIN
//   blink_on  out  display enable for the field being set
//   sec_tick  out  one-cycle pulse on each second increment in RUN
module clock_time_core #(
    parameter int CLK_HZ = 50_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] key_tgl,
    output logic [7:0] hour_bcd,
    output logic [7:0] min_bcd,
    output logic [7:0] sec_bcd,
    output logic [1:0] mode,
    output logic       blink_on,
    output logic       sec_tick
);
    localparam int CW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_HZ - 1);
    localparam logic [CW-1:0] HALF = CW'(CLK_HZ / 2);
    localparam logic [1:0] RUN = 2'b00, SET_HOUR = 2'b01, SET_MIN = 2'b10;

    logic [2:0]    key_q;
    logic [2:0]    press;
    logic [CW-1:0] cnt;
    logic          tick;

    // Each level change of a toggle key is one press.
    assign press    = key_tgl ^ key_q;
    assign tick     = cnt == LAST;
    assign blink_on = (mode == RUN) || (cnt < HALF);

    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] top);
        return (v == top) ? 8'h00 : (v[3:0] == 4'h9) ? {v[7:4] + 4'h1, 4'h0} : v + 8'h01;
    endfunction

    function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] top);
        return (v == 8'h00) ? top : (v[3:0] == 4'h0) ? {v[7:4] - 4'h1, 4'h9} : v - 8'h01;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_q    <= 3'b000;
            cnt      <= '0;
            mode     <= RUN;
            hour_bcd <= 8'h00;
            min_bcd  <= 8'h00;
            sec_bcd  <= 8'h00;
            sec_tick <= 1'b0;
        end else begin
            key_q    <= key_tgl;
            cnt      <= tick ? '0 : cnt + 1'b1;
            sec_tick <= 1'b0;
            if (press[0]) begin
                // Mode press wins over inc/dec; entering SET_HOUR drops any tick this cycle.
                mode <= (mode == RUN) ? SET_HOUR : (mode == SET_HOUR) ? SET_MIN : RUN;
                if (mode == RUN)
                    sec_bcd <= 8'h00;
                if (mode != SET_HOUR)
                    cnt <= '0;
            end else if (mode == RUN) begin
                if (tick) begin
                    sec_tick <= 1'b1;
                    sec_bcd  <= bcd_inc(sec_bcd, 8'h59);
                    if (sec_bcd == 8'h59)
                        min_bcd <= bcd_inc(min_bcd, 8'h59);
                    if (sec_bcd == 8'h59 && min_bcd == 8'h59)
                        hour_bcd <= bcd_inc(hour_bcd, 8'h23);
                end
            end else if (press[1] != press[2]) begin
                if (mode == SET_HOUR)
                    hour_bcd <= press[1] ? bcd_inc(hour_bcd, 8'h23) : bcd_dec(hour_bcd, 8'h23);
                else
                    min_bcd <= press[1] ? bcd_inc(min_bcd, 8'h59) : bcd_dec(min_bcd, 8'h59);
            end
        end
    end
endmodule

// File: tb/tb_clock_time_core.sv
// tb_clock_time_core: directed self-checking bench for clock_time_core at CLK_HZ=10
module tb_clock_time_core;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] key_tgl = 3'b000;
    logic [7:0] hour_bcd, min_bcd, sec_bcd;
    logic [1:0] mode;
    logic       blink_on, sec_tick;

    int cmp_cnt = 0;
    int err_cnt = 0;

    clock_time_core #(.CLK_HZ(10)) dut (
        .clk(clk), .rst_n(rst_n), .key_tgl(key_tgl),
        .hour_bcd(hour_bcd), .min_bcd(min_bcd), .sec_bcd(sec_bcd),
        .mode(mode), .blink_on(blink_on), .sec_tick(sec_tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        cmp_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [2:0] m);
        key_tgl = key_tgl ^ m;
        step();
    endtask

    task automatic run(input int n, output int ticks);
        ticks = 0;
        for (int i = 0; i < n; i++) begin
            step();
            if (sec_tick) ticks++;
        end
    endtask

    initial begin
        int ticks, highs, falls, hour_at, min_at;
        logic prev_blink;
        #12;
        chk("rst_hour", hour_bcd, 8'h00);
        chk("rst_min", min_bcd, 8'h00);
        chk("rst_sec", sec_bcd, 8'h00);
        chk("rst_mode", mode, 2'b00);
        chk("rst_blink", blink_on, 1'b1);
        chk("rst_tick", sec_tick, 1'b0);
        rst_n = 1'b1;

        run(600, ticks);
        chk("t1_ticks", ticks, 60);
        chk("t1_hour", hour_bcd, 8'h00);
        chk("t1_min", min_bcd, 8'h01);
        chk("t1_sec", sec_bcd, 8'h00);

        press(3'b001);
        chk("t2_mode_sh", mode, 2'b01);
        press(3'b100);
        chk("t2_hour23", hour_bcd, 8'h23);
        press(3'b001);
        chk("t2_mode_sm", mode, 2'b10);
        press(3'b100);
        chk("t2_min00", min_bcd, 8'h00);
        press(3'b100);
        chk("t2_min59", min_bcd, 8'h59);
        press(3'b001);
        chk("t2_mode_run", mode, 2'b00);
        ticks = 0; hour_at = -1; min_at = -1;
        for (int i = 1; i <= 600; i++) begin
            step();
            if (sec_tick) ticks++;
            if (hour_bcd != 8'h23 && hour_at < 0) hour_at = i;
            if (min_bcd != 8'h59 && min_at < 0) min_at = i;
            if (i == 599) chk("t2_sec59", sec_bcd, 8'h59);
        end
        chk("t2_ticks", ticks, 60);
        chk("t2_hour_edge", hour_at, 600);
        chk("t2_min_edge", min_at, 600);
        chk("t2_hour", hour_bcd, 8'h00);
        chk("t2_min", min_bcd, 8'h00);
        chk("t2_sec", sec_bcd, 8'h00);

        run(35, ticks);
        chk("t3_sec03", sec_bcd, 8'h03);
        press(3'b001);
        chk("t3_mode", mode, 2'b01);
        chk("t3_sec0", sec_bcd, 8'h00);
        chk("t3_blink0", blink_on, 1'b1);
        ticks = 0; highs = 0; falls = 0; prev_blink = blink_on;
        for (int i = 0; i < 500; i++) begin
            step();
            if (sec_tick) ticks++;
            if (blink_on) highs++;
            if (prev_blink && !blink_on) falls++;
            prev_blink = blink_on;
        end
        chk("t3_ticks", ticks, 0);
        chk("t3_highs", highs, 250);
        chk("t3_falls", falls, 50);
        chk("t3_time", {hour_bcd, min_bcd, sec_bcd}, 24'h000000);

        press(3'b100);
        chk("t4_hdec", hour_bcd, 8'h23);
        press(3'b010);
        chk("t4_hinc", hour_bcd, 8'h00);
        press(3'b001);
        chk("t4_mode", mode, 2'b10);
        press(3'b100);
        chk("t4_mdec", min_bcd, 8'h59);
        press(3'b010);
        chk("t4_minc", min_bcd, 8'h00);
        chk("t4_hour", hour_bcd, 8'h00);

        press(3'b110);
        chk("t5_both_min", min_bcd, 8'h00);
        chk("t5_both_mode", mode, 2'b10);
        press(3'b001);
        chk("t5_run", mode, 2'b00);
        press(3'b001);
        for (int i = 0; i < 12; i++) press(3'b010);
        chk("t5_hour12", hour_bcd, 8'h12);
        press(3'b011);
        chk("t5_mode_win", mode, 2'b10);
        chk("t5_hour_kept", hour_bcd, 8'h12);
        for (int i = 0; i < 40; i++) press(3'b010);
        chk("t5_min40", min_bcd, 8'h40);
        press(3'b100);
        chk("t5_min39", min_bcd, 8'h39);
        for (int i = 0; i < 5; i++) press(3'b100);
        chk("t5_min34", min_bcd, 8'h34);

        #2 rst_n = 1'b0;
        key_tgl = 3'b000;
        #1;
        chk("t6_time", {hour_bcd, min_bcd, sec_bcd}, 24'h000000);
        chk("t6_mode", mode, 2'b00);
        chk("t6_blink", blink_on, 1'b1);
        step();
        chk("t6_hold", mode, 2'b00);
        rst_n = 1'b1;
        key_tgl = 3'b001;
        step();
        chk("t6_press", mode, 2'b01);
        step();
        chk("t6_single", mode, 2'b01);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end
endmodule
